iter_ctrl: RTL and testbench

Parametrised controller for multi-cycle iterative datapath operations (dividers, CORDIC, successive approximation). It sequences an operation through load, iterate and finish phases, driven by the datapath's `zero` flag. Unlike the fixed four-state controller it generalises, it counts iterations against a run-time limit, flags timeouts, supports abort and reports a busy status. It sits between the bus/control logic and one iterative datapath.

---
 rtl/iter_ctrl_pkg.sv | 13 +
 rtl/iter_counter.sv | 30 +++
 rtl/iter_ctrl.sv | 88 ++++++++
 tb/tb_iter_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/iter_ctrl_pkg.sv
// Shared definitions for the iterative-operation controller.
// The state codes are fixed so that datapath benches can decode them.
package iter_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ITER = 3'd2,
    S_DONE = 3'd3,
    S_TOUT = 3'd4
  } state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter with synchronous clear/enable and a compare against lim-1.
module iter_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // lim == 0 never reaches the iterate phase, so the wrapped lim-1 is harmless
  assign last = (cnt_reg == lim - CNT_W'(1));
  assign cnt  = cnt_reg;

endmodule

// File: rtl/iter_ctrl.sv
// Load/iterate/finish sequencer for an iterative datapath, with run-time
// iteration limit, timeout, abort and busy status.
module iter_ctrl
  import iter_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             zero,
  input  logic [CNT_W-1:0] limit,
  output logic             init,
  output logic             do_iter,
  output logic             busy,
  output logic             ready,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_cnt
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] lim_reg;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;
  logic             accept;

  assign accept = (state_reg == S_IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      lim_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        lim_reg <= limit;
      end
    end
  end

  // abort > zero > limit check in every active state
  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE: state_next = accept ? S_INIT : S_IDLE;
      S_INIT: begin
        if (abort)              state_next = S_IDLE;
        else if (zero)          state_next = S_DONE;
        else if (lim_reg == '0) state_next = S_TOUT;
        else                    state_next = S_ITER;
      end
      S_ITER: begin
        if (abort)         state_next = S_IDLE;
        else if (zero)     state_next = S_DONE;
        else if (cnt_last) state_next = S_TOUT;
        else               state_next = S_ITER;
      end
      S_DONE:  state_next = S_IDLE;
      S_TOUT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign cnt_clr = (state_reg == S_INIT);
  assign cnt_en  = (state_reg == S_ITER) && !abort;

  iter_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .lim  (lim_reg),
    .cnt  (iter_cnt),
    .last (cnt_last)
  );

  assign init    = (state_reg == S_INIT);
  assign do_iter = (state_reg == S_ITER);
  assign busy    = (state_reg == S_INIT) || (state_reg == S_ITER);
  assign ready   = (state_reg == S_DONE);
  assign timeout = (state_reg == S_TOUT);

endmodule

// File: tb/tb_iter_ctrl.sv
// Randomized bench for iter_ctrl; each operation's outcome is predicted from
// the phase at which abort, zero or the limit first takes effect.
module tb_iter_ctrl;

  localparam int CNT_W = 8;
  localparam int NEVER = 1000;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             zero;
  logic [CNT_W-1:0] limit;
  logic             init;
  logic             do_iter;
  logic             busy;
  logic             ready;
  logic             timeout;
  logic [CNT_W-1:0] iter_cnt;

  int errors = 0;
  int checks = 0;
  int op_num = 0;

  iter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .zero     (zero),
    .limit    (limit),
    .init     (init),
    .do_iter  (do_iter),
    .busy     (busy),
    .ready    (ready),
    .timeout  (timeout),
    .iter_cnt (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (op %0d)", tag, obs, exp, op_num);
    end
  endtask

  // Phase 0 is the load cycle, phase p>=1 is the p-th iterate cycle.
  // z/a give the phase where zero/abort are pulsed (NEVER = not at all).
  task automatic run_op(input int lim_v, input int z, input int a, input bit noise);
    int lim_phase, t, kind, exp_cnt;
    int n_init, n_iter, n_busy, n_rdy, n_tout, term_cyc, cnt_at_term;
    lim_phase = lim_v;
    t = a;
    if (z < t) t = z;
    if (lim_phase < t) t = lim_phase;
    if (a == t)      kind = 0;      // aborted
    else if (z == t) kind = 1;      // ready
    else             kind = 2;      // timeout
    if (kind == 0)      exp_cnt = (t == 0) ? 0 : t - 1;
    else if (kind == 1) exp_cnt = t;
    else                exp_cnt = lim_v;

    n_init = 0; n_iter = 0; n_busy = 0; n_rdy = 0; n_tout = 0;
    term_cyc = -1; cnt_at_term = -1;
    op_num++;

    start = 1'b1; abort = 1'b0; zero = 1'b0; limit = CNT_W'(lim_v);
    @(posedge clk); #1;
    for (int c = 1; c <= t + 3; c++) begin
      zero  = (c - 1 == z);
      abort = (c - 1 == a);
      start = (noise && c <= t + 1) ? 1'($urandom % 2) : 1'b0;
      limit = noise ? CNT_W'($urandom) : CNT_W'(lim_v);
      if (init)    n_init++;
      if (do_iter) n_iter++;
      if (busy)    n_busy++;
      if (ready || timeout) begin
        term_cyc    = c;
        cnt_at_term = int'(iter_cnt);
      end
      if (ready)   n_rdy++;
      if (timeout) n_tout++;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; zero = 1'b0;

    $display("op %0d: lim=%0d zero@%0d abort@%0d -> kind=%0d iters=%0d cnt=%0d",
             op_num, lim_v, z, a, kind, n_iter, int'(iter_cnt));
    chk("init_cycles", n_init, 1);
    chk("do_iter_cycles", n_iter, t);
    chk("busy_cycles", n_busy, t + 1);
    chk("ready_pulses", n_rdy, (kind == 1) ? 1 : 0);
    chk("timeout_pulses", n_tout, (kind == 2) ? 1 : 0);
    if (kind != 0) begin
      chk("term_cycle", term_cyc, t + 2);
      chk("cnt_at_term", cnt_at_term, exp_cnt);
    end
    chk("iter_cnt_held", int'(iter_cnt), exp_cnt);
    chk("idle_after", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; zero = 1'b0; limit = '0;
    @(posedge clk); #1;
    chk("rst_outs", int'({init, do_iter, busy, ready, timeout}), 0);
    chk("rst_cnt", int'(iter_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(10, 4, NEVER, 1'b0);      // ready after 4 iterations
    run_op(5, NEVER, NEVER, 1'b0);   // timeout after 5
    run_op(0, NEVER, NEVER, 1'b0);   // zero limit, straight to timeout
    run_op(0, 0, NEVER, 1'b0);       // zero in load cycle, ready at k+2
    run_op(10, 3, 3, 1'b1);          // abort beats zero, start pulses ignored
    run_op(255, 255, NEVER, 1'b1);   // full range, limit scrambled mid-run
    run_op(7, 7, NEVER, 1'b0);       // zero in last allowed iteration
    run_op(6, NEVER, 0, 1'b0);       // abort in load cycle
    run_op(1, NEVER, NEVER, 1'b0);

    // asynchronous reset between edges in the middle of iterating
    op_num++;
    start = 1'b1; limit = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_iter", int'(do_iter), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_outs", int'({init, do_iter, busy, ready, timeout}), 0);
    chk("async_rst_cnt", int'(iter_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(busy), 0);
    run_op(3, NEVER, NEVER, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int l, z, a;
      l = $urandom_range(0, 20);
      z = ($urandom % 2) ? int'($urandom_range(0, l + 2)) : NEVER;
      a = ($urandom % 4 == 0) ? int'($urandom_range(0, l + 1)) : NEVER;
      run_op(l, z, a, 1'($urandom % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
